// File: rtl/debug_commit_trace_if.sv
// debug_commit_trace_if: capture-side and drain-side signal bundle for the
// commit-trace buffer. master = core/consumer side, slave = trace buffer.
interface debug_commit_trace_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [31:0]      io_debug_pc;
   logic [31:0]      io_debug_wdata;
   logic [4:0]       io_debug_waddr;
   logic             io_debug_wen;
   logic             io_clear;
   logic             io_trace_valid;
   logic             io_trace_ready;
   logic [31:0]      io_trace_pc;
   logic [4:0]       io_trace_waddr;
   logic [31:0]      io_trace_wdata;
   logic [LVL_W-1:0] io_level;
   logic [31:0]      io_commit_cnt;
   logic [15:0]      io_drop_cnt;
   logic             io_overflow;

   modport master (
      output io_debug_pc, io_debug_wdata, io_debug_waddr, io_debug_wen,
             io_clear, io_trace_ready,
      input  io_trace_valid, io_trace_pc, io_trace_waddr, io_trace_wdata,
             io_level, io_commit_cnt, io_drop_cnt, io_overflow
   );

   modport slave (
      input  io_debug_pc, io_debug_wdata, io_debug_waddr, io_debug_wen,
             io_clear, io_trace_ready,
      output io_trace_valid, io_trace_pc, io_trace_waddr, io_trace_wdata,
             io_level, io_commit_cnt, io_drop_cnt, io_overflow
   );
endinterface

// File: rtl/debug_commit_trace.sv
// debug_commit_trace: captures debug writebacks as {pc, waddr, wdata}
// records into a first-word-fall-through FIFO drained over valid/ready,
// with commit / drop / overflow statistics.
// Optional feature macro: TRACE_SKIP_R0_EN (ignore writebacks to $0).
module debug_commit_trace #(
   parameter int unsigned DEPTH = 16
) (
   input logic                  clock,
   input logic                  reset,
   debug_commit_trace_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t             r_mem [DEPTH];
   rec_t             r_head;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [LVL_W-1:0] r_level;
   logic [31:0]      r_commit;
   logic [15:0]      r_drop;
   logic             r_ovf;

   rec_t             w_rec;
   rec_t             w_head_nxt;
   logic             w_cap;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_full;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [LVL_W-1:0] w_level_nxt;

   // Capture qualification, push/pop/drop decode and next-state of pointers/level
   always_comb begin
      w_rec = '{pc: bus.io_debug_pc, waddr: bus.io_debug_waddr, wdata: bus.io_debug_wdata};
`ifdef TRACE_SKIP_R0_EN
      w_cap = bus.io_debug_wen & (bus.io_debug_waddr != 5'd0);
`else
      w_cap = bus.io_debug_wen;
`endif
      w_full       = (r_level == LVL_W'(DEPTH));
      w_pop        = (r_level != '0) & bus.io_trace_ready;
      w_push       = w_cap & (~w_full | w_pop);
      w_drop       = w_cap & ~w_push;
      w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      w_level_nxt  = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LVL_W'(1);
      end
      // Head is registered; an incoming record that lands exactly at the next
      // read slot (empty FIFO, or last entry being popped) bypasses storage.
      w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_rec : r_mem[w_rd_ptr_nxt];
   end

   // Record storage (not reset, not cleared)
   always_ff @(posedge clock) begin
      if (w_push && !bus.io_clear) begin
         r_mem[r_wr_ptr] <= w_rec;
      end
   end

   // Pointers, level, head register and statistics
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_head   <= '0;
         r_commit <= '0;
         r_drop   <= '0;
         r_ovf    <= 1'b0;
      end else if (bus.io_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_commit <= '0;
         r_drop   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_level  <= w_level_nxt;
         // Head only moves when it will be valid, so it holds once drained
         if (w_level_nxt != '0) begin
            r_head <= w_head_nxt;
         end
         if (w_push) begin
            r_commit <= r_commit + 32'd1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != '1) begin
               r_drop <= r_drop + 16'd1;
            end
         end
      end
   end

   assign bus.io_trace_valid = (r_level != '0);
   assign bus.io_trace_pc    = r_head.pc;
   assign bus.io_trace_waddr = r_head.waddr;
   assign bus.io_trace_wdata = r_head.wdata;
   assign bus.io_level       = r_level;
   assign bus.io_commit_cnt  = r_commit;
   assign bus.io_drop_cnt    = r_drop;
   assign bus.io_overflow    = r_ovf;
endmodule

// File: tb/tb_debug_commit_trace.sv
// tb_debug_commit_trace: table-driven vectors plus hand sequences for
// overflow, full push+pop, clear and asynchronous reset; a queue scoreboard
// checks head records in drain order.
module tb_debug_commit_trace;
   localparam int unsigned DEPTH = 16;
`ifdef TRACE_SKIP_R0_EN
   localparam bit SKIP_R0 = 1'b1;
`else
   localparam bit SKIP_R0 = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   debug_commit_trace_if #(.DEPTH(DEPTH)) bus ();

   debug_commit_trace #(.DEPTH(DEPTH)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   typedef struct {
      logic        wen;
      logic [31:0] pc;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ready;
      logic        clr;
      logic        e_valid;
      int unsigned e_level;
      int unsigned e_commit;
   } vec_t;

   rec_t        sb[$];
   vec_t        tbl[8];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_stats(input string tag, input logic e_valid, input int unsigned e_level,
                              input int unsigned e_commit, input int unsigned e_drop, input logic e_ovf);
      check({tag, "_valid"},  {31'd0, bus.io_trace_valid}, {31'd0, e_valid});
      check({tag, "_level"},  32'(bus.io_level), e_level);
      check({tag, "_commit"}, bus.io_commit_cnt, e_commit);
      check({tag, "_drop"},   32'(bus.io_drop_cnt), e_drop);
      check({tag, "_ovf"},    {31'd0, bus.io_overflow}, {31'd0, e_ovf});
   endtask

   // One clock: drive inputs, compare head against scoreboard, update model, step edge.
   task automatic cycle(input logic wen, input logic [31:0] pc, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic ready, input logic clr);
      int unsigned sz;
      logic        cap;
      logic        pop;
      rec_t        r;
      bus.io_debug_wen   = wen;
      bus.io_debug_pc    = pc;
      bus.io_debug_waddr = waddr;
      bus.io_debug_wdata = wdata;
      bus.io_trace_ready = ready;
      bus.io_clear       = clr;
      #1;
      sz = sb.size();
      check("sb_valid", {31'd0, bus.io_trace_valid}, (sz != 0) ? 32'd1 : 32'd0);
      if (sz != 0) begin
         check("head_pc",    bus.io_trace_pc, sb[0].pc);
         check("head_waddr", 32'(bus.io_trace_waddr), 32'(sb[0].waddr));
         check("head_wdata", bus.io_trace_wdata, sb[0].wdata);
      end
      cap = wen & ~(SKIP_R0 & (waddr == 5'd0));
      pop = (sz != 0) & ready;
      if (clr) begin
         sb.delete();
      end else begin
         if (pop) void'(sb.pop_front());
         if (cap && (sz < DEPTH || pop)) begin
            r.pc = pc; r.waddr = waddr; r.wdata = wdata;
            sb.push_back(r);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned r0;
      logic [31:0] d;
      r0 = SKIP_R0 ? 0 : 1;
      tbl[0] = '{1'b1, 32'hBFC0_0000, 5'd8, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1, 1};
      tbl[1] = '{1'b0, 32'h0,         5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1, 1};
      tbl[2] = '{1'b0, 32'h0,         5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 1};
      tbl[3] = '{1'b1, 32'h8000_0000, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, r0[0], r0, 1 + r0};
      tbl[4] = '{1'b0, 32'h0,         5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 1 + r0};
      tbl[5] = '{1'b1, 32'h0000_0100, 5'd3, 32'h0000_00A5, 1'b1, 1'b0, 1'b1, 1, 2 + r0};
      tbl[6] = '{1'b1, 32'h0000_0104, 5'd4, 32'h0000_00A6, 1'b1, 1'b0, 1'b1, 1, 3 + r0};
      tbl[7] = '{1'b0, 32'h0,         5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 3 + r0};

      bus.io_debug_wen = 1'b0; bus.io_debug_pc = '0; bus.io_debug_waddr = '0;
      bus.io_debug_wdata = '0; bus.io_trace_ready = 1'b0; bus.io_clear = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_stats("rst", 1'b0, 0, 0, 0, 1'b0);
      check("rst_pc", bus.io_trace_pc, 32'h0);
      check("rst_wdata", bus.io_trace_wdata, 32'h0);
      rst_n = 1'b1;

      // Table vectors: single write, drain, $0 write, back-to-back push/pop
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].wen, tbl[i].pc, tbl[i].waddr, tbl[i].wdata, tbl[i].ready, tbl[i].clr);
         check($sformatf("tbl%0d_valid", i), {31'd0, bus.io_trace_valid}, {31'd0, tbl[i].e_valid});
         check($sformatf("tbl%0d_level", i), 32'(bus.io_level), tbl[i].e_level);
         check($sformatf("tbl%0d_commit", i), bus.io_commit_cnt, tbl[i].e_commit);
      end

      // Fill to full, then drops
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
      check_stats("clr0", 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < DEPTH + 3; i++) begin
         d = $urandom;
         cycle(1'b1, 32'h1000 + 32'(i) * 4, 5'((i % 31) + 1), d, 1'b0, 1'b0);
      end
      check_stats("full", 1'b1, 16, 16, 3, 1'b1);

      // Full FIFO with simultaneous push and pop
      cycle(1'b1, 32'h2000, 5'd9, 32'hCAFE_F00D, 1'b1, 1'b0);
      check_stats("fullpp", 1'b1, 16, 17, 3, 1'b1);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
      check_stats("drained", 1'b0, 0, 17, 3, 1'b1);

      // Clear with concurrent capture at level 5, overflow set
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h3000 + 32'(i) * 4, 5'd5, 32'(i) + 32'h50, 1'b0, 1'b0);
      check_stats("pre_clr", 1'b1, 5, 22, 3, 1'b1);
      cycle(1'b1, 32'h3100, 5'd7, 32'h77, 1'b0, 1'b1);
      check_stats("clr", 1'b0, 0, 0, 0, 1'b0);
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
      check("clr_discard_level", 32'(bus.io_level), 32'd0);

      // Asynchronous reset mid-drain at level 7
      for (int i = 0; i < 9; i++) cycle(1'b1, 32'h5000 + 32'(i) * 4, 5'd10, 32'(i) + 32'h900, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
      check("pre_rst_level", 32'(bus.io_level), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check_stats("arst", 1'b0, 0, 0, 0, 1'b0);
      check("arst_pc", bus.io_trace_pc, 32'h0);
      sb.delete();
      bus.io_trace_ready = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_level", 32'(bus.io_level), 32'd0);
      cycle(1'b1, 32'h4000, 5'd12, 32'h4444_4444, 1'b0, 1'b0);
      check_stats("post_rst", 1'b1, 1, 1, 0, 1'b0);
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/debug_commit_trace.md
# debug_commit_trace

Commit-trace capture buffer sitting directly downstream of the core's debug writeback port (`io_debug_pc`/`io_debug_wdata`/`io_debug_waddr`/`io_debug_wen`). Every qualifying register writeback is recorded as a {pc, waddr, wdata} record in a first-word-fall-through FIFO. Records drain over a valid/ready interface to a trace comparator or host link. The block also keeps commit, drop and overflow statistics for difftest bring-up.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, minimum 2
- `LVL_W`, log2(DEPTH)+1, width of the occupancy output (derived, not overridden)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_debug_pc`  in  32  PC of the committing instruction
- `io_debug_wdata`  in  32  writeback data
- `io_debug_waddr`  in  5  writeback register index
- `io_debug_wen`  in  1  writeback valid this cycle
- `io_clear`  in  1  synchronous flush of FIFO and statistics
- `io_trace_valid`  out  1  head record available
- `io_trace_ready`  in  1  consumer accepts head record
- `io_trace_pc`  out  32  head record PC
- `io_trace_waddr`  out  5  head record register index
- `io_trace_wdata`  out  32  head record data
- `io_level`  out  LVL_W  current occupancy, 0..DEPTH
- `io_commit_cnt`  out  32  records accepted into FIFO; wraps modulo 2^32
- `io_drop_cnt`  out  16  records lost to full FIFO; saturates at 0xFFFF
- `io_overflow`  out  1  sticky; set on first drop

## Operation
- Capture condition `cap` = `io_debug_wen`, further qualified per Configuration.
- Pop `pop` = `io_trace_valid & io_trace_ready`.
- Push `push` = `cap & (level < DEPTH | pop)`. A push into a full FIFO is accepted when a pop occurs in the same cycle.
- Drop = `cap & ~push`. On a drop: `io_drop_cnt` += 1, saturating at 0xFFFF; `io_overflow` ← 1; the record is discarded and the FIFO is unchanged.
- Storage: DEPTH-entry register array with read and write pointers of log2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. Full/empty is derived from `level`.
- `level` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `io_commit_cnt` += 1 on every push and wraps to 0 after 0xFFFFFFFF.
- Head outputs always reflect the entry at the read pointer. When `io_trace_valid`=0, they hold their last value and carry no meaning.
- `io_clear` has priority over push, pop and drop in the same cycle. It zeroes pointers, level, both counters and `io_overflow`, and the capture in that cycle is discarded. Storage contents are not cleared.
- Handshake: once `io_trace_valid` is 1, it and the head fields stay stable until popped or cleared.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `io_trace_valid`=0, `io_level`=0, `io_commit_cnt`=0, `io_drop_cnt`=0, `io_overflow`=0
  - head fields = 0; storage is not reset
- Reset may assert at any time, including mid-drain. Outputs go to reset values immediately, and the first capture is possible on the first rising edge after deassertion.
- Latency: a record captured at edge N into an empty FIFO gives `io_trace_valid`=1 with its fields after edge N (visible in cycle N+1). There is no combinational path from the `io_debug_*` inputs to the `io_trace_*` outputs.
- `io_trace_ready` to `io_trace_valid`: combinational only through registered level; the next head is visible the cycle after a pop.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `TRACE_SKIP_R0_EN` defined: `cap` = `io_debug_wen & (io_debug_waddr != 0)`. Writes to $0 are neither recorded nor counted.
- `TRACE_SKIP_R0_EN` undefined: `cap` = `io_debug_wen`. Writes to $0 are recorded like any other register.

## Test plan
- Reset then single write (pc=0xBFC00000, waddr=8, wdata=0x12345678, ready=0):
  - cycle after the capture edge: valid=1 with those fields, level=1, commit_cnt=1
  - after ready=1 for one cycle: valid=0, level=0
- Fill DEPTH=16 with ready=0, then 3 more writes: level=16, drop_cnt=3, overflow=1, commit_cnt=16. Draining returns the first 16 records in order.
- Full FIFO, ready=1 and wen=1 in the same cycle: the push is accepted, level stays 16, drop_cnt is unchanged, and the new record appears last in drain order.
- Write with waddr=0, wdata=0xDEADBEEF:
  - with `TRACE_SKIP_R0_EN`: valid stays 0, commit_cnt=0
  - without it: the record appears and commit_cnt=1
- With level=5 and overflow=1, pulse io_clear together with wen=1: next cycle level=0, valid=0, commit_cnt=0, drop_cnt=0, overflow=0.
- Assert reset asynchronously mid-drain with level=7: outputs go to reset values before the next clock edge; after release, a new write appears with valid=1 and level=1.
